dac_words_to_volts: RTL and testbench

- Inverse of the DAC calibration path: converts a 12-bit DAC code back to a signed 16-bit voltage in 0.1 mV units (25000 = 2.5 V).
- Used for readback, monitor, and loopback checks of the waveform output.
- Calibration points (zero code, 2.5 V code) are loaded at runtime.
- A serial divider computes the reciprocal scale once per calibration; per-sample conversion is a 2-stage multiply/shift pipeline with valid/ready handshakes.

---
 rtl/dac_words_to_volts.sv | 180 ++++++++++++++++++
 tb/tb_dac_words_to_volts.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_words_to_volts.sv
// dac_words_to_volts: converts a 12-bit DAC code back to a signed voltage in
// 0.1 mV units using two runtime calibration points (0 V code, 2.5 V code).
// A serial restoring divider derives the reciprocal scale once per
// calibration; samples then flow through a 2-stage multiply/shift pipeline.
module dac_words_to_volts #(
  parameter int M          = 12,
  parameter int N          = 16,
  parameter int FULL_SCALE = 25000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [M-1:0]        cal_zero,
  input  logic [M-1:0]        cal_tp,
  input  logic                cal_start,
  output logic                cal_busy,
  output logic                cal_done,
  output logic                cal_err,
  input  logic [M-1:0]        in_code,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [N-1:0] out_volts,
  output logic                out_sat,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int QW = 31;          // quotient bits (one per divide cycle)
  localparam int CW = 5;           // divide step counter width
  localparam int RW = M + 2;       // partial remainder width incl. shifted-in bit
  localparam int PW = 32 + M + 1;  // full-precision product width
  localparam logic [QW-1:0] DIVIDEND = QW'(longint'(FULL_SCALE) * 65536);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW);
  localparam longint MAXL = (longint'(1) <<< (N - 1)) - 1;
  localparam logic signed [PW-1:0] VMAX = PW'(MAXL);
  localparam logic signed [PW-1:0] VMIN = PW'(-MAXL - 1);

  typedef enum logic [1:0] {UNCAL, CALC, READY, ERR} state_t;

  state_t state_reg, state_next;

  // calibration / divider state
  logic [M-1:0]         zero_reg, tp_reg;
  logic [CW-1:0]        cnt_reg;
  logic [RW-1:0]        rem_reg, divisor_reg;
  logic [QW-1:0]        quo_reg;
  logic                 neg_reg;
  logic signed [31:0]   scale_reg;

  logic signed [M:0]    delta;
  logic [M:0]           delta_mag;
  logic [RW-1:0]        trial, rem_next;
  logic                 trial_ge;
  logic [QW-1:0]        quo_shift;

  // conversion pipeline
  logic                 advance, accept;
  logic                 s1_valid_reg;
  logic signed [PW-1:0] s1_product_reg;
  logic signed [M:0]    diff_in;
  logic signed [PW-1:0] scale_ext, diff_ext, product, shifted;
  logic signed [N-1:0]  volts_next;
  logic                 sat_next;

  assign cal_busy  = (state_reg == CALC);
  assign cal_done  = (state_reg == READY);
  assign cal_err   = (state_reg == ERR);
  assign advance   = !out_valid || out_ready;
  // cal_start takes priority over a sample offered in the same cycle
  assign in_ready  = (state_reg == READY) && advance && !cal_start;
  assign accept    = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= UNCAL;
    else        state_reg <= state_next;
  end

  // Next-state: cal_start always restarts; CALC ends in ERR or READY
  always_comb begin
    state_next = state_reg;
    if (cal_start) begin
      state_next = CALC;
    end else begin
      case (state_reg)
        CALC: begin
          if (cnt_reg == '0) begin
            if (delta == '0) state_next = ERR;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = READY;
          end
        end
        default: ;
      endcase
    end
  end

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    delta     = $signed({1'b0, tp_reg}) - $signed({1'b0, zero_reg});
    delta_mag = delta[M] ? $unsigned(-delta) : $unsigned(delta);
    trial     = (rem_reg << 1) | RW'(quo_reg[QW-1]);
    trial_ge  = (trial >= divisor_reg);
    rem_next  = trial_ge ? (trial - divisor_reg) : trial;
    quo_shift = {quo_reg[QW-2:0], trial_ge};
  end

  // Calibration latch and serial divider; first CALC cycle sets up the divide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg    <= '0;
      tp_reg      <= '0;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      quo_reg     <= '0;
      neg_reg     <= 1'b0;
      scale_reg   <= '0;
    end else if (cal_start) begin
      zero_reg <= cal_zero;
      tp_reg   <= cal_tp;
      cnt_reg  <= '0;
    end else if (state_reg == CALC) begin
      if (cnt_reg == '0) begin
        divisor_reg <= {1'b0, delta_mag};
        neg_reg     <= delta[M];
        rem_reg     <= '0;
        quo_reg     <= DIVIDEND;
        cnt_reg     <= cnt_reg + 1'b1;
      end else begin
        rem_reg <= rem_next;
        quo_reg <= quo_shift;
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          scale_reg <= neg_reg ? -$signed({1'b0, quo_shift}) : $signed({1'b0, quo_shift});
        end
      end
    end
  end

  // Stage-1 multiply and stage-2 floor shift with saturation
  always_comb begin
    diff_in   = $signed({1'b0, in_code}) - $signed({1'b0, zero_reg});
    scale_ext = {{(PW-32){scale_reg[31]}}, scale_reg};
    diff_ext  = {{(PW-M-1){diff_in[M]}}, diff_in};
    product   = scale_ext * diff_ext;
    shifted   = s1_product_reg >>> 16;
    sat_next  = 1'b0;
    volts_next = shifted[N-1:0];
    if (shifted > VMAX) begin
      volts_next = N'(MAXL);
      sat_next   = 1'b1;
    end else if (shifted < VMIN) begin
      volts_next = N'(-MAXL - 1);
      sat_next   = 1'b1;
    end
  end

  // Pipeline registers: move together on advance, hold on stall, flush on cal_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_product_reg <= '0;
      out_valid      <= 1'b0;
      out_volts      <= '0;
      out_sat        <= 1'b0;
    end else if (cal_start) begin
      s1_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= accept;
      if (accept) s1_product_reg <= product;
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_volts <= volts_next;
        out_sat   <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_dac_words_to_volts.sv
// Bench for dac_words_to_volts: directed calibration/conversion vectors with
// literal expectations, plus a queue-based reference model checked every cycle.
module tb_dac_words_to_volts;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [11:0]        cal_zero, cal_tp, in_code;
  logic               cal_start, in_valid, out_ready;
  logic               cal_busy, cal_done, cal_err, in_ready, out_sat, out_valid;
  logic signed [15:0] out_volts;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q[$];
  logic [16:0] em;
  int          mz;
  longint      ms;

  dac_words_to_volts #(.M(12), .N(16), .FULL_SCALE(25000)) dut (
    .clk(clk), .rst_n(rst_n),
    .cal_zero(cal_zero), .cal_tp(cal_tp), .cal_start(cal_start),
    .cal_busy(cal_busy), .cal_done(cal_done), .cal_err(cal_err),
    .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
    .out_volts(out_volts), .out_sat(out_sat), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: scale = +-floor(FULL_SCALE*65536/|delta|)
  function automatic longint model_scale(input int z, input int t);
    int d;
    longint q;
    d = t - z;
    if (d == 0) return 0;
    q = (longint'(25000) * 65536) / (d < 0 ? -d : d);
    return (d < 0) ? -q : q;
  endfunction

  // Reference: volts = floor(scale*(code-zero)/65536), clamped to 16-bit signed
  function automatic logic [16:0] model_out(input int code, input int z, input longint s);
    longint p, v;
    logic sat;
    p = s * longint'(code - z);
    v = p / 65536;
    if (p < 0 && (p % 65536) != 0) v = v - 1;
    sat = 1'b0;
    if (v > 32767) begin
      v = 32767; sat = 1'b1;
    end else if (v < -32768) begin
      v = -32768; sat = 1'b1;
    end
    return {sat, v[15:0]};
  endfunction

  // Model update on each clock edge: calibration capture or accepted sample
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (cal_start) begin
      mz = int'(cal_zero);
      ms = model_scale(int'(cal_zero), int'(cal_tp));
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(model_out(int'(in_code), mz, ms));
    end
  end

  // Compare process: every valid output against the model queue head
  always @(negedge clk) begin
    if (rst_n) begin
      check("cal_mutex", (32'(cal_busy) + 32'(cal_done) + 32'(cal_err)) > 1, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          em = exp_q[0];
          check("out_volts", out_volts, $signed(em[15:0]));
          check("out_sat", out_sat, em[16]);
          if (out_ready) begin
            $display("xfer volts=%0d sat=%0d", out_volts, out_sat);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic calibrate(input int z, input int t, output int busy,
                           output int done_c, output int err_c);
    busy = 0; done_c = 0; err_c = 0;
    cal_zero = 12'(z); cal_tp = 12'(t); cal_start = 1'b1;
    @(negedge clk);
    tick;
    cal_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (cal_busy) busy++;
      if (cal_done) begin done_c = c; break; end
      if (cal_err)  begin err_c = c;  break; end
      tick;
    end
  endtask

  task automatic run_stream(input int n, input int codes[4], input int ev[4], input int es[4]);
    logic               ov[6];
    logic signed [15:0] vv[6];
    logic               sv[6];
    out_ready = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        in_valid = 1'b1; in_code = 12'(codes[i]);
      end else begin
        in_valid = 1'b0; in_code = '0;
      end
      @(negedge clk);
      if (i < n) check("in_ready_stream", in_ready, 1);
      ov[i] = out_valid; vv[i] = out_volts; sv[i] = out_sat;
      tick;
    end
    in_valid = 1'b0;
    for (int i = 0; i < n + 2; i++) begin
      check("latency_valid", ov[i], (i >= 2) ? 1 : 0);
      if (i >= 2) begin
        check("stream_volts", vv[i], ev[i-2]);
        check("stream_sat", sv[i], es[i-2]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  b, d, e;
    bit  acc, calwait;

    rst_n = 1'b0; cal_zero = '0; cal_tp = '0; cal_start = 1'b0;
    in_code = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_volts", out_volts, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_cal_busy", cal_busy, 0);
    check("rst_cal_done", cal_done, 0);
    check("rst_cal_err", cal_err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_scale", dut.scale_reg, 0);
    rst_n = 1'b1;

    // Reset in the middle of a division
    tick;
    cal_zero = 12'd2048; cal_tp = 12'd1; cal_start = 1'b1;
    tick;
    cal_start = 1'b0;
    repeat (10) tick;
    check("midcalc_busy", cal_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", cal_busy, 0);
    check("midrst_done", cal_done, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_code = 12'd5;
    tick;
    @(negedge clk);
    check("uncal_in_ready", in_ready, 0);
    check("uncal_done", cal_done, 0);
    check("uncal_busy", cal_busy, 0);
    tick;
    in_valid = 1'b0;

    // Calibration zero=2048, tp=1
    calibrate(2048, 1, b, d, e);
    check("cal1_busy_cycles", b, 32);
    check("cal1_done_cycle", d, 33);
    check("cal1_err_cycle", e, 0);
    check("cal1_scale", dut.scale_reg, -800390);
    tick;
    run_stream(4, '{1, 2048, 0, 4095}, '{24999, 0, 25012, -25000}, '{0, 0, 0, 0});

    // Calibration zero=2048, tp=2058: both rails saturate
    tick;
    calibrate(2048, 2058, b, d, e);
    check("cal2_done_cycle", d, 33);
    tick;
    run_stream(2, '{4095, 0, 0, 0}, '{32767, -32768, 0, 0}, '{1, 1, 0, 0});

    // Degenerate calibration
    tick;
    calibrate(1000, 1000, b, d, e);
    check("err_busy_cycles", b, 1);
    check("err_cycle", e, 2);
    check("err_done_cycle", d, 0);
    tick;
    in_valid = 1'b1; in_code = 12'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err_in_ready", in_ready, 0);
      check("err_hold", cal_err, 1);
      check("err_out_valid", out_valid, 0);
      tick;
    end
    in_valid = 1'b0;
    calibrate(2048, 1, b, d, e);
    check("recal_done_cycle", d, 33);
    check("recal_err_cycle", e, 0);
    check("recal_err_clear", cal_err, 0);

    // Backpressure with mid-stream recalibration
    tick;
    calibrate(2048, 3000, b, d, e);
    check("cal3_done_cycle", d, 33);
    tick;
    in_valid = 1'b1; in_code = 12'($urandom_range(0, 4095)); calwait = 1'b0;
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 99) < 30);
      cal_start = (i == 150);
      if (i == 150) begin
        cal_zero = 12'd100; cal_tp = 12'd4000;
      end
      @(negedge clk);
      if (i == 151) check("flush_out_valid", out_valid, 0);
      if (calwait) begin
        if (cal_done) calwait = 1'b0;
        else check("calc_in_ready", in_ready, 0);
      end
      if (i == 150) calwait = 1'b1;
      acc = in_valid && in_ready;
      tick;
      if (acc) in_code = 12'($urandom_range(0, 4095));
    end
    cal_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick;
    @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
